// File: rtl/enc8_3_pend_if.sv
// Handshake bundle between the 8-line request encoder and its producer/consumer.
// The slave modport is the encoder side; master is the environment driving it.
interface enc8_3_pend_if;
   logic [7:0] req_in;
   logic       clr_all;
   logic [2:0] code;
   logic       valid;
   logic       ready;
   logic [7:0] pending;
   logic [3:0] pend_cnt;
   logic       overflow;

   modport master (
      output req_in, clr_all, ready,
      input  code, valid, pending, pend_cnt, overflow
   );

   modport slave (
      input  req_in, clr_all, ready,
      output code, valid, pending, pend_cnt, overflow
   );
endinterface

// File: rtl/enc8_3_pend.sv
// 8-to-3 request encoder with sticky pending buffer and valid/ready output.
// Selection is fixed highest-index priority (RR_MODE=0) or round-robin (RR_MODE=1).
module enc8_3_pend #(
   parameter bit RR_MODE = 1'b0
) (
   input  logic          clk,
   input  logic          rst,
   enc8_3_pend_if.slave  bus
);

   logic [7:0] pending_q, pending_d;
   logic [2:0] code_q, code_d;
   logic       valid_q, valid_d;
   logic       overflow_q, overflow_d;
   logic [2:0] last_q, last_d;
   logic [3:0] pend_cnt_q, pend_cnt_d;

   logic [7:0] served;
   logic [7:0] avail;
   logic [2:0] sel;
   logic [2:0] idx;
   logic       found;
   logic       handshake;

   // NOTE: every always_comb output gets a default first, so no path leaves it unassigned (no latch).
   always_comb begin
      handshake  = valid_q && bus.ready;
      served     = handshake ? (8'b1 << code_q) : 8'b0;
      avail      = pending_q & ~served;
      sel        = 3'd0;
      idx        = 3'd0;
      found      = 1'b0;

      if (RR_MODE) begin
         // k=8 wraps to last_q itself, so the last served line is searched last.
         for (int k = 1; k <= 8; k++) begin
            idx = last_q + 3'(k);
            if (!found && avail[idx]) begin
               sel   = idx;
               found = 1'b1;
            end
         end
      end else begin
         for (int i = 0; i < 8; i++) begin
            if (avail[i]) sel = 3'(i);
         end
      end

      pending_d  = avail | bus.req_in;
      overflow_d = overflow_q | (|(bus.req_in & avail));
      last_d     = handshake ? code_q : last_q;

      if (valid_q && !bus.ready) begin
         code_d  = code_q;
         valid_d = 1'b1;
      end else if (|avail) begin
         code_d  = sel;
         valid_d = 1'b1;
      end else begin
         code_d  = code_q;
         valid_d = 1'b0;
      end

      if (bus.clr_all) begin
         pending_d  = 8'h00;
         overflow_d = 1'b0;
         code_d     = 3'd0;
         valid_d    = 1'b0;
         last_d     = last_q;
      end

      pend_cnt_d = 4'd0;
      for (int i = 0; i < 8; i++) begin
         pend_cnt_d = pend_cnt_d + {3'b000, pending_d[i]};
      end
   end

   // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         pending_q  <= 8'h00;
         code_q     <= 3'd0;
         valid_q    <= 1'b0;
         overflow_q <= 1'b0;
         last_q     <= 3'd7;
         pend_cnt_q <= 4'd0;
      end else begin
         pending_q  <= pending_d;
         code_q     <= code_d;
         valid_q    <= valid_d;
         overflow_q <= overflow_d;
         last_q     <= last_d;
         pend_cnt_q <= pend_cnt_d;
      end
   end

   assign bus.pending  = pending_q;
   assign bus.code     = code_q;
   assign bus.valid    = valid_q;
   assign bus.overflow = overflow_q;
   assign bus.pend_cnt = pend_cnt_q;

endmodule
